mod_counter_ud: RTL
===================

Name: mod_counter_ud

Overview:
- Parametrised, runtime-programmable modulo-N up/down counter for the digital-clock divider chain. Successor to the fixed divide-by-N stage.
- Adds: direction control, count enable, synchronous preload, a runtime modulus that changes only at a safe point, cascade carry, and error flagging.
- Instances chain via CO → EN to form seconds/minutes/hours digits (mod 10, mod 6, mod 24, etc.).

Parameters:
- W, 4, counter width in bits.
- N_DEFAULT, 10, modulus after reset; legal range 2..2^W.

Ports:
- CLK  input  1  clock; all state updates on the falling edge.
- CLEAR  input  1  asynchronous active-high reset.
- EN  input  1  count enable / carry-in from the previous stage.
- UP  input  1  direction: 1 = increment, 0 = decrement.
- LOAD  input  1  synchronous preload strobe.
- LOAD_VAL  input  W  preload value.
- MOD_WR  input  1  modulus write strobe.
- MODULUS  input  W+1  new modulus value.
- COUNT  output  W  current count (registered).
- TC  output  1  terminal count (combinational): UP ? (COUNT == MOD_ACT-1) : (COUNT == 0).
- CO  output  1  cascade carry-out = TC & EN & ~LOAD (combinational).
- WRAP  output  1  registered one-cycle pulse, high in the cycle after a wrap.
- ERR  output  1  sticky error flag.

Behaviour:
- Reset (CLEAR=1, async): COUNT=0, MOD_ACT=N_DEFAULT, pending-modulus flag=0, WRAP=0, ERR=0. Reset holds while CLEAR=1 and overrides any operation in progress.
- Internal registers:
  - MOD_ACT (W+1 bits): the active modulus.
  - MOD_PEND (W+1 bits) plus a valid flag PEND.
- Priority on each falling edge: LOAD > EN count > hold.
- LOAD:
  - If PEND=1, MOD_ACT←MOD_PEND and PEND←0 first; the legality check below uses that updated modulus.
  - If LOAD_VAL < modulus: COUNT←LOAD_VAL.
  - Otherwise: COUNT←0 and ERR←1.
  - WRAP←0.
- EN=1, UP=1:
  - If COUNT == MOD_ACT-1: COUNT←0 and WRAP←1 (wrap event).
  - Otherwise: COUNT←COUNT+1 and WRAP←0.
- EN=1, UP=0:
  - If COUNT == 0: COUNT←(new modulus)-1 and WRAP←1 (wrap event).
  - Otherwise: COUNT←COUNT-1 and WRAP←0.
- EN=0 and LOAD=0: COUNT holds; WRAP←0.
- Modulus write (MOD_WR=1):
  - If 2 ≤ MODULUS ≤ 2^W: MOD_PEND←MODULUS, PEND←1. A later write before application overwrites MOD_PEND (last write wins).
  - If MODULUS is illegal: ignored, ERR←1, PEND unchanged.
- Modulus application:
  - MOD_ACT takes MOD_PEND only at a wrap event or a LOAD, never mid-count.
  - On a wrap event, PEND clears and the new modulus governs the new COUNT value. A down-wrap lands at MOD_PEND-1; an up-wrap lands at 0.
- Simultaneous MOD_WR and wrap/LOAD in the same edge: the wrap/LOAD uses the previously pending value, if any. The new write becomes pending for the next event.
- UP may change on any cycle. TC/CO reflect the current UP value combinationally; no registered state depends on the previous direction.
- Arithmetic:
  - Comparisons use W+1-bit zero-extended COUNT.
  - With modulus 2^W, the up-wrap occurs at all-ones and COUNT never exceeds modulus-1.
- ERR is sticky; only CLEAR clears it.
- Latency:
  - COUNT and WRAP are valid one falling edge after the enabling inputs.
  - TC/CO have zero latency from COUNT, EN, UP and LOAD.

Test Plan:
- Reset/up-count, W=4, N_DEFAULT=10, EN=1, UP=1:
  - COUNT runs 0..9, 0.
  - TC=CO=1 only while COUNT=9.
  - WRAP=1 for exactly the one cycle after 9→0.
  - Assert CLEAR mid-count (COUNT=5) between edges → COUNT=0 and WRAP=0 immediately.
- Down-count, UP=0 from reset:
  - COUNT 0→9→8…→0, with TC=1 while COUNT=0.
  - Drop EN at COUNT=4 for 3 cycles → COUNT holds at 4, CO=0, WRAP=0.
- Deferred modulus:
  - At COUNT=3 (up), write MODULUS=6 → counts 4..9, 0, then 0..5, 0.
  - TC asserts at 9 before the wrap and at 5 after it.
- Modulus write collisions:
  - Write 6, then write 12 before the wrap → next cycle after wrap uses 12 (last write wins).
  - MOD_WR coincident with a wrap edge → the new value applies at the following wrap.
- LOAD and errors:
  - LOAD with LOAD_VAL=7 while EN=1 → COUNT=7 (LOAD wins).
  - LOAD_VAL=12 with modulus 10 → COUNT=0, ERR=1.
  - MOD_WR with MODULUS=1 or 17 → ignored, ERR=1; ERR stays 1 until CLEAR.
- Two-stage cascade (mod 10 → mod 6, CO0 → EN1):
  - 60 enabled edges from reset → stage1 steps on each 9→0 of stage0.
  - Both stages return to 0 with WRAP high on both together after edge 60.

Source files
------------

// File: rtl/mod_counter_ud.sv
// Runtime-programmable modulo-N up/down counter stage for the clock divider chain.
// A new modulus is staged as pending and only takes effect at a wrap or a preload.
module mod_counter_ud #(
    parameter int W         = 4,
    parameter int N_DEFAULT = 10
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         en,
    input  logic         up,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         mod_wr,
    input  logic [W:0]   modulus,
    output logic [W-1:0] count,
    output logic         tc,
    output logic         co,
    output logic         wrap,
    output logic         err
);

    localparam logic [W:0] MOD_RST = (W+1)'(N_DEFAULT);
    localparam logic [W:0] MOD_MIN = (W+1)'(2);
    localparam logic [W:0] MOD_MAX = (W+1)'(1) << W;
    localparam logic [W:0] ONE_X   = (W+1)'(1);

    logic [W:0]   mod_act;
    logic [W:0]   mod_pend;
    logic         pend;

    logic [W:0]   count_x;
    logic [W:0]   mod_eff;
    logic [W-1:0] down_wrap_val;
    logic         at_top;
    logic         at_zero;
    logic         mod_legal;
    logic         load_ok;
    logic         wrap_evt;

    // Terminal detection always uses the active modulus; a pending value is invisible until applied.
    assign count_x       = {1'b0, count};
    assign at_top        = (count_x == mod_act - ONE_X);
    assign at_zero       = (count == '0);
    assign mod_eff       = pend ? mod_pend : mod_act;
    assign down_wrap_val = W'(mod_eff - ONE_X);
    assign mod_legal     = (modulus >= MOD_MIN) && (modulus <= MOD_MAX);
    assign load_ok       = ({1'b0, load_val} < mod_eff);
    assign wrap_evt      = up ? at_top : at_zero;

    assign tc = wrap_evt;
    assign co = tc & en & ~load;

    always_ff @(negedge clk or posedge clear) begin
        if (clear) begin
            count    <= '0;
            mod_act  <= MOD_RST;
            mod_pend <= MOD_RST;
            pend     <= 1'b0;
            wrap     <= 1'b0;
            err      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here mean every test above reads the pre-edge state,
            // so later statements in this block may override earlier ones without ordering hazards.
            wrap <= 1'b0;
            if (load) begin
                mod_act <= mod_eff;
                pend    <= 1'b0;
                if (load_ok) begin
                    count <= load_val;
                end else begin
                    count <= '0;
                    err   <= 1'b1;
                end
            end else if (en) begin
                if (wrap_evt) begin
                    mod_act <= mod_eff;
                    pend    <= 1'b0;
                    wrap    <= 1'b1;
                    count   <= up ? '0 : down_wrap_val;
                end else begin
                    count <= up ? count + W'(1) : count - W'(1);
                end
            end

            // A write on the same edge as a wrap/load stays pending for the next event.
            if (mod_wr) begin
                if (mod_legal) begin
                    mod_pend <= modulus;
                    pend     <= 1'b1;
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule
